// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the direct-mapped,
// write-through data cache.
package dcache_pkg;
  localparam int unsigned INDEX_BITS  = 4;
  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int unsigned LINES       = 1 << INDEX_BITS;
  localparam int unsigned WORDS       = 1 << OFFSET_BITS;

  typedef logic [TAG_BITS-1:0]    tag_t;
  typedef logic [INDEX_BITS-1:0]  index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_e;

  function automatic tag_t addr_tag(input logic [31:0] a);
    return a[31 -: TAG_BITS];
  endfunction

  function automatic index_t addr_index(input logic [31:0] a);
    return a[OFFSET_BITS+2 +: INDEX_BITS];
  endfunction

  function automatic offset_t addr_offset(input logic [31:0] a);
    return a[2 +: OFFSET_BITS];
  endfunction
endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: combinational read, synchronous word write and line
// validate, async clear of the valid bits only.
module dcache_store
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  index_t      rd_idx_i,
  input  offset_t     rd_off_i,
  output logic        rd_valid_o,
  output tag_t        rd_tag_o,
  output logic [31:0] rd_data_o,
  input  logic        wr_en_i,
  input  index_t      wr_idx_i,
  input  offset_t     wr_off_i,
  input  logic [31:0] wr_data_i,
  input  logic        inv_en_i,
  input  index_t      inv_idx_i,
  input  logic        val_en_i,
  input  index_t      val_idx_i,
  input  tag_t        val_tag_i
);
  logic [31:0]      data_q [LINES][WORDS];
  tag_t             tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

  always_ff @(posedge clk) begin
    if (wr_en_i)  data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (val_en_i) tag_q[val_idx_i] <= val_tag_i;
  end

  // Invalidate and validate never target the same cycle (miss detect vs. last refill word).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
      if (val_en_i) valid_q[val_idx_i] <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data-cache controller with
// whole-line refill over a req/ack memory port and saturating hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  state_e      state_q;
  offset_t     cnt_q;
  tag_t        ref_tag_q;
  index_t      ref_idx_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [31:0] hit_q, miss_q;

  tag_t    cpu_tag;
  index_t  cpu_idx;
  offset_t cpu_off;
  logic    rd_valid, hit;
  tag_t    rd_tag;

  logic        st_wr_en, st_inv_en, st_val_en;
  index_t      st_wr_idx;
  offset_t     st_wr_off;
  logic [31:0] st_wr_data;

  assign cpu_tag = addr_tag(cpu_address);
  assign cpu_idx = addr_index(cpu_address);
  assign cpu_off = addr_offset(cpu_address);
  assign hit     = rd_valid && (rd_tag == cpu_tag);

  dcache_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (cpu_idx),
    .rd_off_i   (cpu_off),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (cpu_read_data),
    .wr_en_i    (st_wr_en),
    .wr_idx_i   (st_wr_idx),
    .wr_off_i   (st_wr_off),
    .wr_data_i  (st_wr_data),
    .inv_en_i   (st_inv_en),
    .inv_idx_i  (cpu_idx),
    .val_en_i   (st_val_en),
    .val_idx_i  (ref_idx_q),
    .val_tag_i  (ref_tag_q)
  );

  // Store write port: CPU store hit in IDLE, refill word on ack in REFILL.
  always_comb begin
    st_wr_en   = 1'b0;
    st_wr_idx  = cpu_idx;
    st_wr_off  = cpu_off;
    st_wr_data = cpu_write_data;
    st_inv_en  = 1'b0;
    st_val_en  = 1'b0;
    cpu_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        st_wr_en  = cpu_write && hit;
        // A line under refill stays invalid until its last word lands.
        st_inv_en = !cpu_write && cpu_read && !hit;
        cpu_stall = cpu_write || (cpu_read && !hit);
      end
      S_REFILL: begin
        cpu_stall  = 1'b1;
        st_wr_en   = mem_ack;
        st_wr_idx  = ref_idx_q;
        st_wr_off  = cnt_q;
        st_wr_data = mem_read_data;
        st_val_en  = mem_ack && (cnt_q == offset_t'(WORDS-1));
      end
      S_WRITE: cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ref_tag_q   <= '0;
      ref_idx_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_write) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {cpu_address[31:2], 2'b00};
            mem_wdata_q <= cpu_write_data;
            state_q     <= S_WRITE;
          end else if (cpu_read) begin
            if (hit) begin
              if (hit_q != '1) hit_q <= hit_q + 32'd1;
            end else begin
              if (miss_q != '1) miss_q <= miss_q + 32'd1;
              cnt_q      <= '0;
              ref_tag_q  <= cpu_tag;
              ref_idx_q  <= cpu_idx;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {cpu_tag, cpu_idx, {OFFSET_BITS{1'b0}}, 2'b00};
              state_q    <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            if (cnt_q == offset_t'(WORDS-1)) begin
              mem_req_q <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_q <= {ref_tag_q, ref_idx_q, offset_t'(cnt_q + 1'b1), 2'b00};
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed vector bench for dcache_controller with a behavioural backing memory
// whose ack latency is set per access.
module tb_dcache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_address = '0, cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall, mem_req, mem_we;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backing memory: word at byte address A defaults to 0xB000_0000|A.
  logic [31:0] bmem [256];
  int          ack_delay = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  int          wr_ok = 0;
  logic [31:0] exp_waddr = '0, exp_wdata = '0;
  logic [31:0] raddrs [$];

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 32'hB000_0000 | (i << 2);
    bmem[8'h10] = 32'h11; bmem[8'h11] = 32'h22;
    bmem[8'h12] = 32'h33; bmem[8'h13] = 32'h44;
    forever begin
      @(negedge clk);
      if (mem_req && wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) bmem[mem_address[9:2]] = mem_write_data;
        else begin
          mem_read_data = bmem[mem_address[9:2]];
          raddrs.push_back(mem_address);
        end
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt = mem_req ? wcnt + 1 : 0;
      end
      if (mem_req) begin
        req_cycles++;
        if (mem_we && mem_address == exp_waddr && mem_write_data == exp_wdata) wr_ok++;
      end
    end
  end

  typedef struct {
    logic        wr, rd;
    logic [31:0] addr, wdata;
    int          dly, stall, req;
    logic [31:0] rdata;
    logic        chkd;
    int          hits, miss;
    logic        refill;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] wd, input int dly, input int st, input int rq,
                              input logic [31:0] rdat, input logic chkd, input int h,
                              input int m, input logic rf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.dly = dly; v.stall = st;
    v.req = rq; v.rdata = rdat; v.chkd = chkd; v.hits = h; v.miss = m; v.refill = rf;
    return v;
  endfunction

  vec_t vecs [14];

  task automatic run_vec(input int i, input vec_t v);
    int          stalls;
    logic [31:0] rdata;
    logic [31:0] base;
    ack_delay = v.dly;
    @(posedge clk); #1;
    req_cycles = 0; wr_ok = 0; raddrs.delete();
    exp_waddr = {v.addr[31:2], 2'b00}; exp_wdata = v.wdata;
    cpu_read = v.rd; cpu_write = v.wr; cpu_address = v.addr; cpu_write_data = v.wdata;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls <= 50) begin
      stalls++;
      @(negedge clk);
    end
    rdata = cpu_read_data;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(v.stall));
    chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(v.req));
    if (v.chkd) chk($sformatf("v%0d_rdata", i), rdata, v.rdata);
    if (v.wr) chk($sformatf("v%0d_write_stable", i), 32'(wr_ok), 32'(v.req));
    chk($sformatf("v%0d_hit_count", i), hit_count, 32'(v.hits));
    chk($sformatf("v%0d_miss_count", i), miss_count, 32'(v.miss));
    if (v.refill) begin
      base = {v.addr[31:4], 4'h0};
      chk($sformatf("v%0d_refill_words", i), 32'(raddrs.size()), 32'd4);
      for (int k = 0; k < 4 && k < raddrs.size(); k++)
        chk($sformatf("v%0d_refill_addr%0d", i, k), raddrs[k], base + 32'(4 * k));
    end
  endtask

  task automatic reset_mid_refill();
    int n;
    @(posedge clk); #1;
    ack_delay = 0; raddrs.delete();
    cpu_read = 1'b1; cpu_address = 32'h80;
    n = 0;
    while (raddrs.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_two_acks", 32'(raddrs.size()), 32'd2);
    @(posedge clk); #1;
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    rst = 1'b0; cpu_read = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mid_hits", hit_count, 32'd0);
    chk("rst_mid_misses", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //          wr    rd    addr        wdata        dly st rq rdata          chkd  h  m  refill
    vecs[0]  = mk(1'b0, 1'b1, 32'h40,  32'h0,       0, 5, 4, 32'h11,        1'b1, 0, 1, 1'b1);
    vecs[1]  = mk(1'b0, 1'b1, 32'h48,  32'h0,       0, 0, 0, 32'h33,        1'b1, 1, 1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h44,  32'hDEAD,    2, 4, 3, 32'h0,         1'b0, 1, 1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 32'h44,  32'h0,       0, 0, 0, 32'hDEAD,      1'b1, 2, 1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 32'h140, 32'h0,       0, 5, 4, 32'hB000_0140, 1'b1, 2, 2, 1'b1);
    vecs[5]  = mk(1'b0, 1'b1, 32'h40,  32'h0,       0, 5, 4, 32'h11,        1'b1, 2, 3, 1'b1);
    vecs[6]  = mk(1'b1, 1'b0, 32'h200, 32'h1234,    0, 2, 1, 32'h0,         1'b0, 2, 3, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h200, 32'h0,       0, 5, 4, 32'h1234,      1'b1, 2, 4, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 32'h204, 32'h0,       0, 0, 0, 32'hB000_0204, 1'b1, 3, 4, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h4C,  32'h0,       0, 0, 0, 32'h44,        1'b1, 4, 4, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 32'h48,  32'h5555,    1, 3, 2, 32'h0,         1'b0, 4, 4, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 32'h48,  32'h0,       0, 0, 0, 32'h5555,      1'b1, 5, 4, 1'b0);
    // after the mid-refill reset: counters restart, all lines invalid
    vecs[12] = mk(1'b0, 1'b1, 32'h80,  32'h0,       0, 5, 4, 32'hB000_0080, 1'b1, 0, 1, 1'b1);
    vecs[13] = mk(1'b0, 1'b1, 32'h4C,  32'h0,       0, 5, 4, 32'h44,        1'b1, 0, 2, 1'b1);

    #3;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_hits", hit_count, 32'd0);
    chk("reset_misses", miss_count, 32'd0);
    #9 rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (i == 12) reset_mid_refill();
      run_vec(i, vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
